// File: rtl/mx_pkg.sv
// Shared constants and types for MX-format <-> bf16 conversion blocks.
package mx_pkg;

    localparam int BF16_BIAS = 127;

    typedef logic [15:0] bf16_t;

    localparam bf16_t BF16_POS_ZERO = 16'h0000;
    localparam bf16_t BF16_NEG_ZERO = 16'h8000;
    localparam bf16_t BF16_POS_INF  = 16'h7F80;
    localparam bf16_t BF16_NEG_INF  = 16'hFF80;
    localparam bf16_t BF16_QNAN     = 16'h7FC0;

    localparam logic [7:0] MX_EXP_NAN = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dec_state_e;

endpackage

// File: rtl/mxi_elem_to_bf16.sv
// Combinational decode of one signed MXINT element plus its shared exponent into bf16.
module mxi_elem_to_bf16
    import mx_pkg::*;
#(
    parameter int bit_width = 8
) (
    input  logic signed [bit_width-1:0] elem_i,
    input  logic        [7:0]           exp_i,
    output bf16_t                       bf16_o
);

    logic                 sign;
    logic [bit_width-1:0] mag;
    logic [7:0]           mag8;
    logic [2:0]           lead;
    logic [6:0]           mant;
    logic signed [9:0]    exp_s;

    // Flush to signed zero below the normal range, saturate to signed infinity above it.
    function automatic bf16_t sat_pack(input logic sign_f, input logic signed [9:0] e,
                                       input logic [6:0] m);
        if (e <= 10'sd0) begin
            return sign_f ? BF16_NEG_ZERO : BF16_POS_ZERO;
        end else if (e >= 10'sd255) begin
            return sign_f ? BF16_NEG_INF : BF16_POS_INF;
        end else begin
            return {sign_f, e[7:0], m};
        end
    endfunction

    always_comb begin
        sign = elem_i[bit_width-1];
        // Negating the most negative code wraps back to 2^(bit_width-1), which is the right magnitude unsigned.
        mag  = sign ? $unsigned(-elem_i) : $unsigned(elem_i);
        // Scaling to 8 bits puts the binary point after bit 6 for every bit_width,
        // so exp = E - (bit_width-2) + p reduces to E + lead - 6.
        mag8 = 8'(mag) << (8 - bit_width);
        lead = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (mag8[b]) begin
                lead = 3'(b);
            end
        end
        mant  = 7'(mag8 << (3'd7 - lead));
        exp_s = $signed({2'b00, exp_i}) + $signed({7'b000_0000, lead}) - 10'sd6;

        if (exp_i == MX_EXP_NAN) begin
            bf16_o = BF16_QNAN;
        end else if (mag8 == 8'd0) begin
            bf16_o = BF16_POS_ZERO;
        end else begin
            bf16_o = sat_pack(sign, exp_s, mant);
        end
    end

endmodule

// File: rtl/conv_mxi8tobf16.sv
// Block-buffered MXINT -> bf16 decoder: accepts a whole block, streams it out `lanes` values per beat.
module conv_mxi8tobf16
    import mx_pkg::*;
#(
    parameter  int bit_width = 8,
    parameter  int k         = 32,
    parameter  int lanes     = 8,
    localparam int BEATS     = k / lanes,
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [k*bit_width-1:0]   i_mx_vec,
    input  logic [7:0]               i_mx_exp,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [lanes*16-1:0]      o_bf16_vec,
    output logic [BEAT_W-1:0]        o_beat,
    output logic                     o_last
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam int                SLICE_W   = lanes * bit_width;

    dec_state_e state_q, state_d;

    logic [k*bit_width-1:0] vec_q;
    logic [7:0]             exp_q;

    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   last_q, last_d;
    logic [lanes*16-1:0]    bf16_q, bf16_d;

    logic                   accept;
    logic                   consume;
    logic                   advance;
    logic [BEAT_W-1:0]      beat_inc;
    logic [SLICE_W-1:0]     slice;
    logic [7:0]             slice_exp;
    logic [lanes*16-1:0]    dec;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_SEND;
            ST_SEND: if (consume && last_q && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; o_ready is combinational from i_ready so a new block can chase the last beat.
    always_comb begin
        o_valid = (state_q == ST_SEND);
        o_ready = !o_valid || (i_ready && last_q);
    end

    assign accept   = i_valid && o_ready;
    assign consume  = o_valid && i_ready;
    assign advance  = consume && !last_q;
    assign beat_inc = beat_q + BEAT_W'(1);

    // A new block always starts from its own slice 0; otherwise fetch the following beat from the buffer.
    always_comb begin
        if (accept) begin
            slice     = i_mx_vec[SLICE_W-1:0];
            slice_exp = i_mx_exp;
        end else begin
            slice     = vec_q[int'(beat_inc)*SLICE_W +: SLICE_W];
            slice_exp = exp_q;
        end
    end

    for (genvar j = 0; j < lanes; j++) begin : g_lane
        mxi_elem_to_bf16 #(
            .bit_width (bit_width)
        ) u_dec (
            .elem_i (slice[j*bit_width +: bit_width]),
            .exp_i  (slice_exp),
            .bf16_o (dec[j*16 +: 16])
        );
    end

    always_comb begin
        beat_d = beat_q;
        last_d = last_q;
        bf16_d = bf16_q;
        if (accept) begin
            beat_d = '0;
            last_d = (BEATS == 1);
            bf16_d = dec;
        end else if (advance) begin
            beat_d = beat_inc;
            last_d = (beat_inc == LAST_BEAT);
            bf16_d = dec;
        end else if (consume) begin
            beat_d = '0;
            last_d = 1'b0;
        end
    end

    // Output register stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_q <= '0;
            last_q <= 1'b0;
            bf16_q <= '0;
        end else begin
            beat_q <= beat_d;
            last_q <= last_d;
            bf16_q <= bf16_d;
        end
    end

    // Block buffer: pure data, only written on accept, so a reset simply abandons its contents.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            vec_q <= i_mx_vec;
            exp_q <= i_mx_exp;
        end
    end

    assign o_bf16_vec = bf16_q;
    assign o_beat     = beat_q;
    assign o_last     = last_q;

endmodule

// File: tb/tb_conv_mxi8tobf16.sv
// Scoreboard bench for conv_mxi8tobf16: directed corner blocks plus randomized blocks under random backpressure.
module tb_conv_mxi8tobf16;

    localparam int BW    = 8;
    localparam int K     = 32;
    localparam int L     = 8;
    localparam int BEATS = K / L;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [K*BW-1:0]  i_mx_vec;
    logic [7:0]       i_mx_exp;
    logic             o_valid;
    logic             i_ready;
    logic [L*16-1:0]  o_bf16_vec;
    logic [1:0]       o_beat;
    logic             o_last;

    typedef struct {
        logic [L*16-1:0] data;
        int              beat;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 i_clk = ~i_clk;

    conv_mxi8tobf16 #(
        .bit_width (BW),
        .k         (K),
        .lanes     (L)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mx_vec   (i_mx_vec),
        .i_mx_exp   (i_mx_exp),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_bf16_vec (o_bf16_vec),
        .o_beat     (o_beat),
        .o_last     (o_last)
    );

    // Reference: value = elem * 2^(E-127) * 2^-(BW-2), re-encoded as truncated bf16.
    function automatic logic [15:0] ref_bf16(input int elem, input int e_shared);
        int   mag;
        int   lg;
        int   e;
        int   frac;
        logic s;
        if (e_shared == 255) return 16'h7FC0;
        if (elem == 0) return 16'h0000;
        s   = (elem < 0);
        mag = s ? -elem : elem;
        lg  = 0;
        while ((mag >> (lg + 1)) != 0) lg++;
        e = e_shared - (BW - 2) + lg;
        if (e <= 0) return s ? 16'h8000 : 16'h0000;
        if (e >= 255) return s ? 16'hFF80 : 16'h7F80;
        frac = ((mag - (1 << lg)) * 128) / (1 << lg);
        return {s, 8'(e), 7'(frac)};
    endfunction

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endfunction

    function automatic void push_block(input logic [K*BW-1:0] v, input logic [7:0] e);
        for (int b = 0; b < BEATS; b++) begin
            beat_t x;
            for (int j = 0; j < L; j++) begin
                logic signed [BW-1:0] el;
                el = v[(b*L + j)*BW +: BW];
                x.data[j*16 +: 16] = ref_bf16(int'(el), int'(e));
            end
            x.beat = b;
            x.last = (b == BEATS - 1);
            exp_q.push_back(x);
        end
    endfunction

    function automatic logic [K*BW-1:0] rand_vec();
        logic [K*BW-1:0] v;
        for (int i = 0; i < K; i++) v[i*BW +: BW] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic logic [7:0] rand_exp();
        case ($urandom_range(0, 7))
            0:       return 8'hFF;
            1:       return 8'd0;
            2:       return 8'($urandom_range(1, 7));
            3:       return 8'($urandom_range(248, 254));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Monitor: pushes expected beats on accept, pops and compares on every consumed beat.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                exp_q.delete();
            end else begin
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: actual beat %0d with empty scoreboard", o_beat);
                    end else begin
                        beat_t b;
                        b = exp_q.pop_front();
                        chk("beat_data", 128'(o_bf16_vec), 128'(b.data));
                        chk("beat_index", 128'(o_beat), 128'(b.beat));
                        chk("beat_last", 128'(o_last), 128'(b.last));
                    end
                end
                if (i_valid && o_ready) push_block(i_mx_vec, i_mx_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [K*BW-1:0] v, input logic [7:0] e);
        logic acc;
        acc      = 1'b0;
        i_mx_vec = v;
        i_mx_exp = e;
        i_valid  = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual o_ready stuck low, required accept within 200 cycles");
        end
    endtask

    task automatic drain();
        logic idle;
        idle = 1'b0;
        for (int t = 0; t < 200 && !idle; t++) begin
            cyc();
            idle = !o_valid;
        end
        if (!idle) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: actual o_valid still high, required idle within 200 cycles");
        end
    endtask

    task automatic random_phase(input int n_blocks);
        int   sent;
        logic pend;
        logic acc;
        sent = 0;
        pend = 1'b0;
        for (int t = 0; t < 5000 && (sent < n_blocks || o_valid); t++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if (!pend && sent < n_blocks && $urandom_range(0, 2) != 0) begin
                i_mx_vec = rand_vec();
                i_mx_exp = rand_exp();
                i_valid  = 1'b1;
                pend     = 1'b1;
            end
            @(negedge i_clk);
            acc = i_valid && o_ready;
            @(posedge i_clk);
            #1;
            if (acc) begin
                pend    = 1'b0;
                i_valid = 1'b0;
                sent++;
            end
        end
        i_ready = 1'b1;
        if (sent < n_blocks || o_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL random_timeout: actual %0d blocks sent, required %0d", sent, n_blocks);
        end
    endtask

    initial begin
        logic [K*BW-1:0] v;
        logic [L*16-1:0] held;
        logic [15:0]     lit_a [6];
        int              accepted_at;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_mx_vec = '0;
        i_mx_exp = 8'd0;
        lit_a    = '{16'h3F80, 16'hBF80, 16'hC000, 16'h3C80, 16'h0000, 16'h3FFE};

        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_valid", 128'(o_valid), 128'(0));
        chk("reset_ready", 128'(o_ready), 128'(1));
        chk("reset_beat", 128'(o_beat), 128'(0));
        chk("reset_last", 128'(o_last), 128'(0));
        chk("reset_data", 128'(o_bf16_vec), 128'(0));

        i_rst_n = 1'b1;
        i_ready = 1'b1;

        // Known decodes at E=127
        v = rand_vec();
        v[0*BW +: BW] = 8'd64;
        v[1*BW +: BW] = 8'hC0;
        v[2*BW +: BW] = 8'h80;
        v[3*BW +: BW] = 8'd1;
        v[4*BW +: BW] = 8'd0;
        v[5*BW +: BW] = 8'd127;
        send(v, 8'd127);
        for (int j = 0; j < 6; j++) chk("known_e127_lane", 128'(o_bf16_vec[j*16 +: 16]), 128'(lit_a[j]));
        drain();

        // Shared NaN exponent
        send(rand_vec(), 8'hFF);
        for (int j = 0; j < L; j++) chk("nan_lane", 128'(o_bf16_vec[j*16 +: 16]), 128'(16'h7FC0));
        drain();

        // Overflow to -inf and underflow flush
        v = rand_vec();
        v[0*BW +: BW] = 8'h80;
        send(v, 8'd254);
        chk("overflow_neg_inf", 128'(o_bf16_vec[15:0]), 128'(16'hFF80));
        drain();
        v = rand_vec();
        v[0*BW +: BW] = 8'd1;
        v[1*BW +: BW] = 8'hFF;
        send(v, 8'd1);
        chk("flush_pos_zero", 128'(o_bf16_vec[15:0]), 128'(16'h0000));
        chk("flush_neg_zero", 128'(o_bf16_vec[31:16]), 128'(16'h8000));
        drain();

        // Backpressure on beat 1
        send(rand_vec(), 8'($urandom_range(100, 150)));
        chk("first_beat_index", 128'(o_beat), 128'(0));
        chk("busy_ready", 128'(o_ready), 128'(0));
        cyc();
        i_ready = 1'b0;
        held    = o_bf16_vec;
        chk("stall_enter_beat", 128'(o_beat), 128'(1));
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("stall_beat", 128'(o_beat), 128'(1));
            chk("stall_data", 128'(o_bf16_vec), 128'(held));
            chk("stall_ready", 128'(o_ready), 128'(0));
            chk("stall_valid", 128'(o_valid), 128'(1));
        end
        i_ready = 1'b1;
        drain();

        // Back-to-back blocks with no bubble
        send(rand_vec(), 8'd130);
        i_mx_vec    = rand_vec();
        i_mx_exp    = 8'd120;
        i_valid     = 1'b1;
        accepted_at = -1;
        for (int c = 0; c < 2*BEATS; c++) begin
            @(negedge i_clk);
            chk("b2b_valid", 128'(o_valid), 128'(1));
            chk("b2b_beat", 128'(o_beat), 128'(c % BEATS));
            if (i_valid && o_ready) accepted_at = c;
            @(posedge i_clk);
            #1;
            if (accepted_at == c) i_valid = 1'b0;
        end
        chk("b2b_accept_cycle", 128'(accepted_at), 128'(BEATS - 1));
        @(negedge i_clk);
        chk("b2b_idle_after", 128'(o_valid), 128'(0));
        cyc();

        // Asynchronous reset in the middle of a block
        send(rand_vec(), 8'd127);
        cyc();
        cyc();
        chk("pre_reset_beat", 128'(o_beat), 128'(2));
        i_rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 128'(o_valid), 128'(0));
        chk("mid_reset_ready", 128'(o_ready), 128'(1));
        chk("mid_reset_beat", 128'(o_beat), 128'(0));
        cyc();
        i_rst_n = 1'b1;
        chk("post_reset_ready", 128'(o_ready), 128'(1));
        chk("post_reset_beat", 128'(o_beat), 128'(0));
        send(rand_vec(), 8'd140);
        chk("post_reset_first_beat", 128'(o_beat), 128'(0));
        drain();

        random_phase(24);
        drain();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_mxi8tobf16.md
# conv_mxi8tobf16

Decodes one MXINT block (k signed integer elements plus one shared 8-bit exponent) back to bf16. It is the inverse of the bf16→MXINT8 encoder. It sits on the read side of MX-compressed storage and feeds bf16 consumers. It accepts a whole block through a valid/ready handshake, holds it in a block buffer, and streams the decoded bf16 values out `lanes` elements per beat under output backpressure.

## Interface
- `bit_width`, 8: element width, two's complement. Legal range 2..8, so decode is exact.
- `k`, 32: elements per block.
- `lanes`, 8: bf16 elements per output beat. `k % lanes == 0`.
- `i_clk`  in  1: clock, rising edge.
- `i_rst_n`  in  1: reset, asynchronous assert, active-low.
- `i_valid`  in  1: input block valid.
- `o_ready`  out  1: block accepted on an edge where `i_valid && o_ready`.
- `i_mx_vec`  in  `bit_width` x [k]: signed elements.
- `i_mx_exp`  in  8: shared exponent E, bias 127.
- `o_valid`  out  1: output beat valid.
- `i_ready`  in  1: beat consumed on an edge where `o_valid && i_ready`.
- `o_bf16_vec`  out  16 x [lanes]: decoded beat, element j = block element `beat*lanes + j`.
- `o_beat`  out  `$clog2(k/lanes)` (min 1): beat index within the block.
- `o_last`  out  1: high on the final beat, `o_beat == k/lanes-1`.

## Operation
- Element value = elem × 2^(E−127) × 2^−(bit_width−2). This is a 1.(bit_width−2) fixed-point element.
- Per-element decode:
  - elem == 0 → 0x0000.
  - Otherwise: sign = elem MSB; mag = |elem|, computed bit_width wide, so −2^(bit_width−1) is legal.
  - p = position of the leading one in mag.
  - exp = E − (bit_width−2) + p, computed as a signed 10-bit value.
  - Mantissa = the bits of mag below the leading one, left-aligned into 7 bits and zero-filled. No rounding.
- Exponent boundaries:
  - exp ≤ 0 → signed zero (0x0000 or 0x8000). No subnormals.
  - exp ≥ 255 → signed infinity (0x7F80 or 0xFF80).
- E == 0xFF → every element of the block decodes to 0x7FC0 (qNaN), regardless of element value.
- FSM has two states:
  - IDLE (o_valid=0). On accept: capture the block and E into the buffer, register beat 0 into the outputs, go to SEND.
  - SEND (o_valid=1). On consume of a non-last beat: increment the beat counter and register the next beat.
  - On consume of the last beat: if a new block is accepted on the same edge, load its beat 0 and stay in SEND. Otherwise go to IDLE.
- `o_ready = !o_valid || (i_ready && o_last)`. This is combinational from `i_ready`, which gives back-to-back blocks with no bubble.
- While `o_valid && !i_ready`: all outputs and the buffer hold.

## Timing
- Latency: a block accepted at edge N presents beat 0 after edge N. One block occupies exactly k/lanes consumed beats.
- Sustained throughput is one beat per cycle when `i_ready` stays high.
- Reset (asynchronous, including mid-block) sets:
  - o_valid=0, o_beat=0, o_last=0, o_bf16_vec all 0x0000, FSM to IDLE.
  - o_ready therefore reads 1.
  - Any partial block is discarded.
- First accept is possible on the first rising edge after `i_rst_n` deasserts.
- If `i_valid` is high when o_ready=0, the block is not taken. The upstream holds it.
- The decode path is combinational from buffer or input to the output register, for a single cycle: a priority encoder plus a shifter of at most 8 bits.

## Structure
- Shared package `mx_pkg` holds:
  - `BF16_BIAS = 127`.
  - `BF16_POS_INF = 16'h7F80`, `BF16_NEG_INF = 16'hFF80`, `BF16_QNAN = 16'h7FC0`.
  - `MX_EXP_NAN = 8'hFF`.
  - typedef `bf16_t` (16-bit packed).
- Sub-module `mxi_elem_to_bf16` is purely combinational. It is instantiated `lanes` times and maps (elem, E) → bf16.
- The top level contains the block buffer, beat counter, FSM and output register.
- The beat mux selects buffer slice `o_beat+1` when advancing within a block. It selects the input slice 0 when loading a new block.

## Test plan
Defaults: k=32, lanes=8, bit_width=8.
- E=127, elements 64, −64, −128, 1, 0, 127 → 0x3F80, 0xBF80, 0xC000, 0x3C80, 0x0000, 0x3FFE.
- E=0xFF with arbitrary elements → all 32 outputs are 0x7FC0.
- E=254 with elem −128 → 0xFF80. E=1 with elem 1 → 0x0000, and elem −1 → 0x8000 (flush).
- One block with i_ready low for 3 cycles at beat 1 → beat 1 outputs and o_beat held stable. Four beats are delivered in order 0..3, o_last only on beat 3, and o_ready=0 until beat 3 is consumed.
- Two blocks back-to-back with i_valid and i_ready high → block 2 is accepted on the edge that consumes block 1 beat 3. Eight consecutive valid beats, no bubble.
- i_rst_n pulsed low during beat 2 → o_valid falls immediately. After release, o_ready=1 and o_beat=0. The next block starts at beat 0 with correct data.
